// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// rr_arbiter8_if: request/grant bundle between requesters (master) and the arbiter (slave).
// Revision 1.0
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// rr_arbiter8: 8-way round-robin arbiter, rotating priority pointer and bounded hold tenure.
// Revision 1.0
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  wire logic    clk,
  input  wire logic    rst,
  rr_arbiter8_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       gnt_oh;
  logic [2:0]       gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  logic [2:0]       win;
  logic             win_found;
  logic [2:0]       cand;
  logic [7:0]       win_oh;
  logic             owner_drop;
  logic             hold_limit;

  // Search starts at ptr and wraps naturally through 3-bit arithmetic.
  always_comb begin
    win       = 3'd0;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!win_found && bus.req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < 8; i++) begin : g_dec
      assign win_oh[i] = (win == 3'(i));
    end
  endgenerate

  assign owner_drop = bus.done || !bus.req[gnt_idx];
  assign hold_limit = (hold_cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt_oh    <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= GRANT;
            gnt_idx   <= win;
            gnt_oh    <= win_oh;
            gnt_valid <= 1'b1;
            hold_cnt  <= CNT_W'(1);
            ptr       <= win + 3'd1;
          end
        end
        GRANT: begin
          // A voluntary release wins over the timeout when both occur together.
          if (owner_drop) begin
            state     <= IDLE;
            gnt_oh    <= 8'h00;
            gnt_valid <= 1'b0;
          end else if (hold_limit) begin
            state     <= IDLE;
            gnt_oh    <= 8'h00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt_oh    <= 8'h00;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_oh;
  assign bus.gnt_idx   = gnt_idx;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// tb_rr_arbiter8: scoreboard bench for rr_arbiter8, directed scenarios plus random traffic.
// Revision 1.0
module tb_rr_arbiter8;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  bit   m_busy;
  int   m_ptr;
  int   m_idx;
  int   m_hold;
  bit   m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model(input logic [7:0] r, input logic d, input logic rs);
    bit found;
    m_to = 1'b0;
    if (rs) begin
      m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_hold = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found  = 1'b1;
          m_idx  = (m_ptr + k) % 8;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_hold = 1;
        m_ptr  = (m_idx + 1) % 8;
      end
    end else if (d || !r[m_idx]) begin
      m_busy = 1'b0;
    end else if (m_hold == MAX_HOLD) begin
      m_busy = 1'b0;
      m_to   = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    exp_t e;
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    model(r, d, rs);
    e.gnt   = m_busy ? (8'h01 << m_idx) : 8'h00;
    e.idx   = 3'(m_idx);
    e.valid = m_busy;
    e.to    = m_to;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("sb_gnt",     32'(bus.gnt),       32'(e.gnt));
      check("sb_idx",     32'(bus.gnt_idx),   32'(e.idx));
      check("sb_valid",   32'(bus.gnt_valid), 32'(e.valid));
      check("sb_timeout", 32'(bus.timeout),   32'(e.to));
    end
  endtask

  task automatic do_reset();
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
  endtask

  int hc;

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    m_busy = 0; m_ptr = 0; m_idx = 0; m_hold = 0; m_to = 0;

    // reset state
    do_reset();
    check("rst_gnt",   32'(bus.gnt),       32'h00);
    check("rst_valid", 32'(bus.gnt_valid), 32'd0);
    check("rst_to",    32'(bus.timeout),   32'd0);

    // single request, then ptr must have moved to 3
    step(8'h04, 1'b0, 1'b0);
    check("single_gnt", 32'(bus.gnt),     32'h04);
    check("single_idx", 32'(bus.gnt_idx), 32'd2);
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    check("single_rel", 32'(bus.gnt),     32'h00);
    check("single_idx_hold", 32'(bus.gnt_idx), 32'd2);
    step(8'hFF, 1'b0, 1'b0);
    check("single_ptr3", 32'(bus.gnt_idx), 32'd3);
    step(8'hFF, 1'b1, 1'b0);

    // fair rotation with exactly one dead cycle per grant
    do_reset();
    for (int g = 0; g < 9; g++) begin
      step(8'hFF, 1'b0, 1'b0);
      check("rot_idx",   32'(bus.gnt_idx),   32'(g % 8));
      check("rot_valid", 32'(bus.gnt_valid), 32'd1);
      step(8'hFF, 1'b1, 1'b0);
      check("rot_dead",  32'(bus.gnt_valid), 32'd0);
    end

    // pointer wrap
    do_reset();
    step(8'h80, 1'b0, 1'b0);
    check("wrap_7", 32'(bus.gnt_idx), 32'd7);
    step(8'h80, 1'b1, 1'b0);
    step(8'h81, 1'b0, 1'b0);
    check("wrap_0", 32'(bus.gnt_idx), 32'd0);
    step(8'h81, 1'b1, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    check("wrap_sole7", 32'(bus.gnt), 32'h80);
    step(8'h80, 1'b1, 1'b0);

    // hold timeout
    do_reset();
    hc = 0;
    step(8'h20, 1'b0, 1'b0);
    hc += int'(bus.gnt == 8'h20);
    for (int i = 0; i < 15; i++) begin
      step(8'h20, 1'b0, 1'b0);
      hc += int'(bus.gnt == 8'h20);
      check("to_early", 32'(bus.timeout), 32'd0);
    end
    check("to_tenure", 32'(hc), 32'd16);
    step(8'h20, 1'b0, 1'b0);
    check("to_pulse", 32'(bus.timeout),   32'd1);
    check("to_rel",   32'(bus.gnt_valid), 32'd0);
    step(8'h20, 1'b0, 1'b0);
    check("to_regrant", 32'(bus.gnt),     32'h20);
    check("to_clear",   32'(bus.timeout), 32'd0);

    // owner drop
    step(8'h00, 1'b0, 1'b0);
    check("drop_rel", 32'(bus.gnt_valid), 32'd0);
    check("drop_to",  32'(bus.timeout),   32'd0);

    // done coinciding with hold limit
    do_reset();
    step(8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(8'h10, 1'b0, 1'b0);
    step(8'h10, 1'b1, 1'b0);
    check("tie_rel", 32'(bus.gnt_valid), 32'd0);
    check("tie_to",  32'(bus.timeout),   32'd0);

    // reset mid-grant
    do_reset();
    step(8'h08, 1'b0, 1'b0);
    check("mid_gnt", 32'(bus.gnt), 32'h08);
    step(8'h08, 1'b0, 1'b1);
    check("mid_rst_gnt", 32'(bus.gnt),     32'h00);
    check("mid_rst_idx", 32'(bus.gnt_idx), 32'd0);
    check("mid_rst_to",  32'(bus.timeout), 32'd0);
    step(8'h09, 1'b0, 1'b0);
    check("mid_first0", 32'(bus.gnt), 32'h01);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
